// File: rtl/lcell_cfg_loader.sv
// lcell_cfg_loader: serial configuration loader for the logic-cell L-fragment.
// Bits arrive MSB-first over a valid/ready handshake into a shadow register.
// A trailing even-parity bit is checked, and only a clean frame is committed
// to lFragBitInfo, in a single cycle. The logic cell therefore never sees a
// partially loaded truth table.
// Optional feature macro: LCELL_CFG_READBACK_EN adds cfg_dout. cfg_dout
// streams the previously active word out while the new word streams in.
module lcell_cfg_loader #(
  parameter int                   CFG_WIDTH = 16,
  parameter logic [CFG_WIDTH-1:0] RESET_CFG = '0
) (
  input  logic                 QCK,
  input  logic                 QRT,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic                 cfg_din,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic [CFG_WIDTH-1:0] lFragBitInfo,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic                 cfg_busy
`ifdef LCELL_CFG_READBACK_EN
  ,
  output logic                 cfg_dout
`endif
);

  // Counter must be able to hold CFG_WIDTH itself; it saturates there and never wraps.
  localparam int CNT_W = $clog2(CFG_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic [CFG_WIDTH-1:0] shadow_reg;
  logic [CFG_WIDTH-1:0] active_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 ready_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 err_reg;

  logic xfer;
  logic last_data_bit;
  logic parity_bad;
  logic in_frame_next;

  // A bit moves only when both sides agree.
  // Ready comes from a flop, so there is no combinational path from valid.
  assign xfer          = cfg_valid & ready_reg;
  assign last_data_bit = (cnt_reg == CNT_W'(CFG_WIDTH - 1));
  // Even parity over data plus parity bit: any odd total is an error.
  assign parity_bad    = ^{shadow_reg, cfg_din};
  assign in_frame_next = (state_next == SHIFT) || (state_next == PARITY);

  assign cfg_ready    = ready_reg;
  assign cfg_busy     = busy_reg;
  assign cfg_done     = done_reg;
  assign cfg_err      = err_reg;
  assign lFragBitInfo = active_reg;

  // State register.
  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. Abort wins over a simultaneous transfer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cfg_start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cfg_abort) begin
          state_next = IDLE;
        end else if (xfer && last_data_bit) begin
          state_next = PARITY;
        end
      end
      PARITY: begin
        if (cfg_abort) begin
          state_next = IDLE;
        end else if (xfer) begin
          state_next = parity_bad ? IDLE : COMMIT;
        end
      end
      COMMIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake and status flags are registered from the next state.
  // They line up exactly with the state they describe.
  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      ready_reg <= in_frame_next;
      busy_reg  <= in_frame_next;
      done_reg  <= (state_reg == COMMIT);
    end
  end

  // Shadow capture, bit counting and the sticky error flag.
  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      shadow_reg <= '0;
      cnt_reg    <= '0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cfg_start) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
          end
        end
        SHIFT: begin
          if (!cfg_abort && xfer) begin
            shadow_reg <= {shadow_reg[CFG_WIDTH-2:0], cfg_din};
            cnt_reg    <= cnt_reg + CNT_W'(1);
          end
        end
        PARITY: begin
          if (!cfg_abort && xfer && parity_bad) begin
            err_reg <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Active word: the only place the logic cell's configuration changes.
  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      active_reg <= RESET_CFG;
    end else if (state_reg == COMMIT) begin
      active_reg <= shadow_reg;
    end
  end

`ifdef LCELL_CFG_READBACK_EN
  logic [CFG_WIDTH-1:0] rb_reg;

  // Readback: snapshot the active word at frame start.
  // Then shift it out in step with the incoming bits.
  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      rb_reg <= '0;
    end else if (state_reg == IDLE && cfg_start) begin
      rb_reg <= active_reg;
    end else if (state_reg == SHIFT && !cfg_abort && xfer) begin
      rb_reg <= {rb_reg[CFG_WIDTH-2:0], 1'b0};
    end
  end

  assign cfg_dout = (state_reg == SHIFT) & rb_reg[CFG_WIDTH-1];
`endif

  // Sanity properties on the loader's own invariants.
  // cfg_done is only high in the idle cycle that follows a commit.
  a_done_not_busy: assert property (@(posedge QCK) disable iff (QRT) cfg_done |-> !cfg_busy);

  a_cnt_bound: assert property (@(posedge QCK) disable iff (QRT) cnt_reg <= CNT_W'(CFG_WIDTH));

endmodule

// File: tb/tb_lcell_cfg_loader.sv
// Testbench for lcell_cfg_loader.
// A frame-level model collects each frame's bits in a queue.
// The model predicts every output, and a compare process checks them on
// every falling edge. Directed tests add literal checks that pin the model.
// Readback checks are compiled in when LCELL_CFG_READBACK_EN is defined.
module tb_lcell_cfg_loader;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_start;
  logic         cfg_abort;
  logic         cfg_din;
  logic         cfg_valid;
  logic         cfg_ready;
  logic         cfg_done;
  logic         cfg_err;
  logic         cfg_busy;
  logic [W-1:0] lfrag;
`ifdef LCELL_CFG_READBACK_EN
  logic         cfg_dout;
  logic [W-1:0] rb_seen = '0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lcell_cfg_loader #(.CFG_WIDTH(W), .RESET_CFG(16'h0000)) dut (
    .QCK          (clk),
    .QRT          (rst),
    .cfg_start    (cfg_start),
    .cfg_abort    (cfg_abort),
    .cfg_din      (cfg_din),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .lFragBitInfo (lfrag),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .cfg_busy     (cfg_busy)
`ifdef LCELL_CFG_READBACK_EN
    ,
    .cfg_dout     (cfg_dout)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  bit           m_collect   = 1'b0;
  bit           m_bits[$];
  logic [W-1:0] m_active    = '0;
  logic [W-1:0] m_old       = '0;
  logic [W-1:0] m_pend_word = '0;
  bit           m_pend      = 1'b0;
  bit           m_done      = 1'b0;
  bit           m_err       = 1'b0;
  int           m_ones;
  logic [W-1:0] m_word;

  // Model update at each clock edge and on reset assertion.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_collect = 1'b0;
      m_bits.delete();
      m_active  = 16'h0000;
      m_pend    = 1'b0;
      m_done    = 1'b0;
      m_err     = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_pend) begin
        m_active = m_pend_word;
        m_done   = 1'b1;
        m_pend   = 1'b0;
      end else if (!m_collect) begin
        if (cfg_start) begin
          m_collect = 1'b1;
          m_bits.delete();
          m_err     = 1'b0;
          m_old     = m_active;
        end
      end else if (cfg_abort) begin
        m_collect = 1'b0;
      end else if (cfg_valid) begin
        m_bits.push_back(cfg_din);
        if (m_bits.size() == W + 1) begin
          m_ones = 0;
          foreach (m_bits[i]) m_ones += int'(m_bits[i]);
          for (int i = 0; i < W; i++) m_word[W-1-i] = m_bits[i];
          m_collect = 1'b0;
          if (m_ones % 2 != 0) m_err = 1'b1;
          else begin
            m_pend      = 1'b1;
            m_pend_word = m_word;
          end
        end
      end
    end
  end

  function automatic logic exp_dout();
    if (m_collect && m_bits.size() < W) return m_old[W-1-m_bits.size()];
    return 1'b0;
  endfunction

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    chk("ready", 32'(cfg_ready), 32'(m_collect));
    chk("busy",  32'(cfg_busy),  32'(m_collect));
    chk("done",  32'(cfg_done),  32'(m_done));
    chk("err",   32'(cfg_err),   32'(m_err));
    chk("lfrag", 32'(lfrag),     32'(m_active));
`ifdef LCELL_CFG_READBACK_EN
    chk("dout",  32'(cfg_dout),  32'(exp_dout()));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise start with a valid data bit alongside.
  // The loader must ignore that bit in IDLE.
  task automatic start_frame();
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_din   = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
  endtask

  // Send frame bits [first, first+n) MSB-first; frame = {word, parity}.
  // During gaps, din carries the inverted bit so a wrongly accepted bit shows up.
  task automatic send_bits(input logic [W:0] frame, input int first, input int n, input bit gaps);
    for (int i = first; i < first + n; i++) begin
      bit v;
      do begin
        v         = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        cfg_valid = v;
        cfg_din   = v ? frame[W-i] : ~frame[W-i];
`ifdef LCELL_CFG_READBACK_EN
        if (v && i < W) rb_seen[W-1-i] = cfg_dout;
`endif
        tick();
      end while (!v);
      cfg_valid = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    cfg_din   = 1'b0;
    cfg_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    tick();

    // 1: reset / idle
    chk("t1_lfrag", 32'(lfrag), 32'h0000);
    chk("t1_ready", 32'(cfg_ready), 32'h0);
    chk("t1_done",  32'(cfg_done), 32'h0);
    chk("t1_err",   32'(cfg_err), 32'h0);

    // 2: clean load of A5C3, parity 0
    start_frame();
    send_bits({16'hA5C3, 1'b0}, 0, W + 1, 1'b0);
    chk("t2_done_commit_cycle", 32'(cfg_done), 32'h0);
    chk("t2_lfrag_before",      32'(lfrag), 32'h0000);
    tick();
    chk("t2_done",  32'(cfg_done), 32'h1);
    chk("t2_lfrag", 32'(lfrag), 32'hA5C3);
    chk("t2_err",   32'(cfg_err), 32'h0);
    tick();
    chk("t2_done_drop", 32'(cfg_done), 32'h0);

    // 3: bad parity on 8000
    start_frame();
    send_bits({16'h8000, 1'b0}, 0, W + 1, 1'b0);
    tick();
    tick();
    chk("t3_err",   32'(cfg_err), 32'h1);
    chk("t3_lfrag", 32'(lfrag), 32'hA5C3);
    start_frame();
    chk("t3_err_cleared", 32'(cfg_err), 32'h0);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    chk("t3_busy_after_abort", 32'(cfg_busy), 32'h0);

    // 4: gappy load of 0F0F with start held high (ignored mid-frame),
    //    and abort during the commit cycle (ignored)
    start_frame();
    cfg_start = 1'b1;
    send_bits({16'h0F0F, 1'b0}, 0, W + 1, 1'b1);
    cfg_start = 1'b0;
    cfg_abort = 1'b1;
    tick();
    chk("t4_lfrag", 32'(lfrag), 32'h0F0F);
    chk("t4_done",  32'(cfg_done), 32'h1);
    tick();
    cfg_abort = 1'b0;
    chk("t4_idle_abort_busy", 32'(cfg_busy), 32'h0);

    // 5: abort after 9 bits (abort beats a simultaneous transfer), then 1234
    start_frame();
    send_bits({16'hFFFF, 1'b0}, 0, 9, 1'b0);
    cfg_abort = 1'b1;
    cfg_valid = 1'b1;
    cfg_din   = 1'b1;
    tick();
    cfg_abort = 1'b0;
    cfg_valid = 1'b0;
    chk("t5_busy_abort",  32'(cfg_busy), 32'h0);
    chk("t5_lfrag_abort", 32'(lfrag), 32'h0F0F);
    start_frame();
    send_bits({16'h1234, 1'b1}, 0, W + 1, 1'b0);
    tick();
    chk("t5_lfrag", 32'(lfrag), 32'h1234);
    tick();
    start_frame();
    send_bits({16'hFFFF, 1'b0}, 0, 5, 1'b0);
    rst = 1'b1;
    #1;
    chk("t5_rst_lfrag", 32'(lfrag), 32'h0000);
    chk("t5_rst_busy",  32'(cfg_busy), 32'h0);
    chk("t5_rst_ready", 32'(cfg_ready), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 6: reload 1234, then BEEF (readback streams the old word)
    start_frame();
    send_bits({16'h1234, 1'b1}, 0, W + 1, 1'b0);
    tick();
    tick();
    chk("t6_lfrag_1234", 32'(lfrag), 32'h1234);
    start_frame();
    send_bits({16'hBEEF, 1'b1}, 0, W + 1, 1'b0);
    tick();
    chk("t6_lfrag", 32'(lfrag), 32'hBEEF);
    chk("t6_err",   32'(cfg_err), 32'h0);
`ifdef LCELL_CFG_READBACK_EN
    chk("t6_dout_seq", 32'(rb_seen), 32'h1234);
`endif
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
